wdt_service_sequencer: RTL
==========================

// Module: wdt_service_sequencer
// PURPOSE
//  AXI write master that configures and services the watchdog behind the WDT AXI slave (WTOCNT/WDEN/WDLIVE).
//  On start it programs the timeout, enables the WDT, then kicks it every KICK_PERIOD cycles or on software request.
//  It also disables the WDT on request. Sits on the master side of the bus, next to the CPU master port.
// PARAMETERS
//  KICK_PERIOD  1000           cycles between automatic kicks, counted in RUN; legal range >=1, 32-bit
//  AXI_ID       8'h01          value driven on AWID_M
//  BASE_ADDR    32'h1001_0000  WDT base; WDEN=+0x100, WDLIVE=+0x200, WTOCNT=+0x300
// PORTS
//  ACLK       in   1   clock
//  ARESET     in   1   asynchronous reset, active-high
//  start      in   1   1-cycle pulse: begin configuration; honoured only in IDLE
//  stop       in   1   1-cycle pulse: disable WDT; honoured in any non-IDLE state
//  sw_kick    in   1   1-cycle pulse: request an immediate kick
//  cfg_tocnt  in   32  timeout value, sampled when start is accepted
//  AWID_M/AWADDR_M/AWLEN_M/AWSIZE_M/AWBURST_M  out  8/32/4/3/2  write address
//  AWVALID_M  out 1 ; AWREADY_M  in 1
//  WDATA_M out 32 ; WSTRB_M out 4 ; WLAST_M out 1 ; WVALID_M out 1 ; WREADY_M in 1
//  BID_M in 8 ; BRESP_M in 2 ; BVALID_M in 1 ; BREADY_M out 1
//  busy       out  1   high in any state other than IDLE
//  running    out  1   high in RUN, KICK_LIVE and KICK_EN
//  err        out  1   sticky: set by a rejected start or BRESP!=0; cleared on the next accepted start
//  kick_cnt   out  16  number of completed kicks; wraps at 0xFFFF; cleared on accepted start
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs in IDLE, kick timer 0, pending-kick and pending-stop flags 0.
//  Bus FSM BUS_IDLE->BUS_AW->BUS_W->BUS_B->BUS_IDLE handles one single-beat write at a time.
//   Fixed fields: AWLEN=0, AWSIZE=3'b010, AWBURST=2'b01, WSTRB=4'hF, WLAST=WVALID.
//   BUS_AW: AWVALID=1; advance when AWVALID&AWREADY.
//   BUS_W: WVALID=1; advance when WREADY.
//   BUS_B: BREADY=1; on BVALID, report done and check BRESP.
//   The bus request from BUS_IDLE goes to BUS_AW on the next edge, so AWVALID rises 1 cycle after the request.
//   AWADDR and WDATA are held stable from AW issue until the B handshake, because the slave samples WDATA
//   for the whole transaction. They are 0 in BUS_IDLE.
//   BID_M is not checked.
//  Top FSM: IDLE, CFG_CNT, CFG_EN, RUN, KICK_LIVE, KICK_EN, STOP_LIVE.
//   Each write state issues exactly one transaction and leaves when B completes.
//   IDLE + start: if cfg_tocnt==0, set err (the slave ignores zero data) and stay in IDLE.
//     Otherwise latch cfg_tocnt, clear err and kick_cnt, and go to CFG_CNT.
//   CFG_CNT writes BASE+0x300 with data=cfg_tocnt -> CFG_EN.
//   CFG_EN writes BASE+0x100 with data=1 -> RUN; the kick timer loads KICK_PERIOD-1.
//   RUN: the timer decrements each cycle.
//     Priority: pending stop -> STOP_LIVE; else timer==0 or pending kick -> KICK_LIVE.
//   KICK_LIVE writes BASE+0x200 with data=1; this restarts the WDT and clears WDEN in the slave -> KICK_EN.
//   KICK_EN writes BASE+0x100 with data=1 -> RUN.
//     On completion: kick_cnt+1, timer reloads KICK_PERIOD-1, pending kick cleared.
//   STOP_LIVE writes BASE+0x200 with data=1, leaving the WDT disabled -> IDLE.
//  sw_kick in RUN is serviced on the next edge.
//   Any other non-IDLE state sets a one-deep pending flag; extra pulses merge.
//   A sw_kick in IDLE is dropped.
//  stop is latched as pending and acted on only in RUN, so an in-flight transaction or kick pair always completes.
//   stop during CFG_* completes configuration first.
//   stop and sw_kick in the same cycle: stop wins and the pending kick is discarded.
//  BRESP!=0 on any write: set err, finish the B handshake, go to IDLE with no further writes.
//  start while busy is ignored and does not set err.
//  ARESET asserted mid-transaction drops AWVALID/WVALID/BREADY immediately; no completion is reported.
// TESTING
//  1. start with cfg_tocnt=0x200 and an always-ready slave -> writes 0x10010300/0x200, then 0x10010100/1; running=1.
//  2. KICK_PERIOD=8 in RUN -> writes 0x10010200/1 then 0x10010100/1, repeating; kick_cnt increments by 1 per pair.
//  3. sw_kick and stop in the same RUN cycle -> only 0x10010200/1 is written, then IDLE; kick_cnt unchanged.
//  4. AWREADY delayed 5 cycles and BVALID delayed 3 cycles -> AW/W fields stable throughout; exactly one transaction.
//  5. start with cfg_tocnt=0 -> err=1, no AWVALID; a following start with 0x40 -> err clears and config runs.
//  6. BRESP=2'b10 on the CFG_EN write -> err=1, back in IDLE, no kick writes.
//     ARESET mid-BUS_W -> all outputs 0 immediately.

Source files
------------

// File: rtl/wdt_service_sequencer.sv
// wdt_service_sequencer
//   AXI write master that programs, enables and periodically kicks the
//   watchdog behind the WDT AXI slave (WTOCNT / WDEN / WDLIVE registers).
//   The watchdog can also be disabled on request.
//
// Ports
//   ACLK, ARESET            clock, asynchronous active-high reset
//   start, stop, sw_kick    1-cycle control pulses
//   cfg_tocnt               timeout value, sampled when start is accepted
//   AW*_M, W*_M, B*_M       AXI write channels (single-beat writes only)
//   busy                    top FSM is not in IDLE
//   running                 top FSM is in RUN, KICK_LIVE or KICK_EN
//   err                     sticky; set by a zero-timeout start or BRESP!=0
//   kick_cnt                completed kick pairs, wraps at 0xFFFF
module wdt_service_sequencer #(
    parameter logic [31:0] KICK_PERIOD = 32'd1000,
    parameter logic [7:0]  AXI_ID      = 8'h01,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    input  logic        stop,
    input  logic        sw_kick,
    input  logic [31:0] cfg_tocnt,
    output logic [7:0]  AWID_M,
    output logic [31:0] AWADDR_M,
    output logic [3:0]  AWLEN_M,
    output logic [2:0]  AWSIZE_M,
    output logic [1:0]  AWBURST_M,
    output logic        AWVALID_M,
    input  logic        AWREADY_M,
    output logic [31:0] WDATA_M,
    output logic [3:0]  WSTRB_M,
    output logic        WLAST_M,
    output logic        WVALID_M,
    input  logic        WREADY_M,
    input  logic [7:0]  BID_M,
    input  logic [1:0]  BRESP_M,
    input  logic        BVALID_M,
    output logic        BREADY_M,
    output logic        busy,
    output logic        running,
    output logic        err,
    output logic [15:0] kick_cnt
);

    typedef enum logic [1:0] {BUS_IDLE, BUS_AW, BUS_W, BUS_B} bus_t;
    typedef enum logic [2:0] {IDLE, CFG_CNT, CFG_EN, RUN, KICK_LIVE, KICK_EN, STOP_LIVE} top_t;

    localparam logic [31:0] ADDR_WDEN   = BASE_ADDR + 32'h100;
    localparam logic [31:0] ADDR_WDLIVE = BASE_ADDR + 32'h200;
    localparam logic [31:0] ADDR_WTOCNT = BASE_ADDR + 32'h300;

    bus_t        r_bus;
    top_t        r_top;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [31:0] r_tocnt;
    logic [31:0] r_timer;
    logic        r_pend_kick;
    logic        r_pend_stop;
    logic        r_err;
    logic [15:0] r_kick_cnt;

    logic        w_wr_state;
    logic        w_req;
    logic        w_done;
    logic        w_berr;
    logic        w_active;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        w_unused;

    // BID is not checked; single outstanding write makes it redundant.
    assign w_unused = ^BID_M;

    // A write state only ever sees the bus idle in its first cycle: the bus
    // returns to BUS_IDLE on the same edge that the top FSM leaves the state.
    assign w_wr_state = (r_top == CFG_CNT) || (r_top == CFG_EN) || (r_top == KICK_LIVE) ||
                        (r_top == KICK_EN) || (r_top == STOP_LIVE);
    assign w_req      = w_wr_state && (r_bus == BUS_IDLE);
    assign w_done     = (r_bus == BUS_B) && BVALID_M;
    assign w_berr     = w_done && (BRESP_M != 2'b00);

    always_comb begin
        w_addr = 32'd0;
        w_data = 32'd0;
        case (r_top)
            CFG_CNT:   begin w_addr = ADDR_WTOCNT; w_data = r_tocnt; end
            CFG_EN:    begin w_addr = ADDR_WDEN;   w_data = 32'd1;   end
            KICK_LIVE: begin w_addr = ADDR_WDLIVE; w_data = 32'd1;   end
            KICK_EN:   begin w_addr = ADDR_WDEN;   w_data = 32'd1;   end
            STOP_LIVE: begin w_addr = ADDR_WDLIVE; w_data = 32'd1;   end
            default:   begin w_addr = 32'd0;       w_data = 32'd0;   end
        endcase
    end

    // Bus FSM: one single-beat write at a time. Address and data are held
    // from AW issue until the B handshake, and are 0 while idle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_bus    <= BUS_IDLE;
            r_awaddr <= 32'd0;
            r_wdata  <= 32'd0;
        end else begin
            case (r_bus)
                BUS_IDLE: if (w_req) begin
                    r_bus    <= BUS_AW;
                    r_awaddr <= w_addr;
                    r_wdata  <= w_data;
                end
                BUS_AW: if (AWREADY_M) r_bus <= BUS_W;
                BUS_W:  if (WREADY_M)  r_bus <= BUS_B;
                BUS_B:  if (BVALID_M) begin
                    r_bus    <= BUS_IDLE;
                    r_awaddr <= 32'd0;
                    r_wdata  <= 32'd0;
                end
                default: r_bus <= BUS_IDLE;
            endcase
        end
    end

    // Top FSM
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_top       <= IDLE;
            r_tocnt     <= 32'd0;
            r_timer     <= 32'd0;
            r_pend_kick <= 1'b0;
            r_pend_stop <= 1'b0;
            r_err       <= 1'b0;
            r_kick_cnt  <= 16'd0;
        end else begin
            // Pending requests collect in every busy state; stop discards
            // any kick request. State-specific code below may override.
            if (r_top != IDLE) begin
                if (stop) begin
                    r_pend_stop <= 1'b1;
                    r_pend_kick <= 1'b0;
                end else if (sw_kick) begin
                    r_pend_kick <= 1'b1;
                end
            end

            if (w_berr) begin
                // Failed write: abandon the sequence, no further writes.
                r_err       <= 1'b1;
                r_top       <= IDLE;
                r_pend_kick <= 1'b0;
                r_pend_stop <= 1'b0;
            end else begin
                case (r_top)
                    IDLE: begin
                        r_pend_kick <= 1'b0;
                        r_pend_stop <= 1'b0;
                        if (start) begin
                            if (cfg_tocnt == 32'd0) begin
                                // The slave ignores a zero timeout; flag it.
                                r_err <= 1'b1;
                            end else begin
                                r_tocnt    <= cfg_tocnt;
                                r_err      <= 1'b0;
                                r_kick_cnt <= 16'd0;
                                r_top      <= CFG_CNT;
                            end
                        end
                    end
                    CFG_CNT: if (w_done) r_top <= CFG_EN;
                    CFG_EN: if (w_done) begin
                        r_top   <= RUN;
                        r_timer <= KICK_PERIOD - 32'd1;
                    end
                    RUN: begin
                        if (r_pend_stop || stop) begin
                            r_top       <= STOP_LIVE;
                            r_pend_stop <= 1'b0;
                            r_pend_kick <= 1'b0;
                        end else if ((r_timer == 32'd0) || r_pend_kick || sw_kick) begin
                            r_top <= KICK_LIVE;
                        end else begin
                            r_timer <= r_timer - 32'd1;
                        end
                    end
                    // Writing WDLIVE also clears WDEN in the slave, hence the
                    // re-enable write that follows.
                    KICK_LIVE: if (w_done) r_top <= KICK_EN;
                    KICK_EN: if (w_done) begin
                        r_top       <= RUN;
                        r_kick_cnt  <= r_kick_cnt + 16'd1;
                        r_timer     <= KICK_PERIOD - 32'd1;
                        r_pend_kick <= 1'b0;
                    end
                    STOP_LIVE: if (w_done) begin
                        r_top       <= IDLE;
                        r_pend_kick <= 1'b0;
                        r_pend_stop <= 1'b0;
                    end
                    default: r_top <= IDLE;
                endcase
            end
        end
    end

    // Fixed AXI fields are driven only while a transaction is active so
    // that every output is 0 out of reset and between writes.
    assign w_active  = (r_bus != BUS_IDLE);
    assign AWID_M    = w_active ? AXI_ID : 8'd0;
    assign AWADDR_M  = r_awaddr;
    assign AWLEN_M   = 4'd0;
    assign AWSIZE_M  = w_active ? 3'b010 : 3'b000;
    assign AWBURST_M = w_active ? 2'b01 : 2'b00;
    assign AWVALID_M = (r_bus == BUS_AW);
    assign WDATA_M   = r_wdata;
    assign WSTRB_M   = w_active ? 4'hF : 4'h0;
    assign WVALID_M  = (r_bus == BUS_W);
    assign WLAST_M   = WVALID_M;
    assign BREADY_M  = (r_bus == BUS_B);

    assign busy      = (r_top != IDLE);
    assign running   = (r_top == RUN) || (r_top == KICK_LIVE) || (r_top == KICK_EN);
    assign err       = r_err;
    assign kick_cnt  = r_kick_cnt;

endmodule
